sym_fir_filter: RTL and testbench



---
 rtl/fir_pkg.sv | 31 +++
 rtl/sym_fir_filter_if.sv | 17 +
 rtl/fir_preadd_mult.sv | 21 ++
 rtl/sym_fir_filter.sv | 76 +++++++
 tb/tb_sym_fir_filter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types, sizes and default coefficient set for the symmetric FIR filter.
// Revision 1.0 - initial release
`default_nettype none

package fir_pkg;

  localparam int NTAPS = 21;
  localparam int DW    = 18;
  localparam int CW    = 18;
  localparam int NHALF = (NTAPS - 1) / 2;
  localparam int PW    = DW + 1 + CW;               // pre-added sample times coefficient
  localparam int ACC_W = PW + $clog2(NTAPS);

  typedef logic signed [DW-1:0]    sample_t;
  typedef logic signed [CW-1:0]    coef_t;
  typedef logic signed [PW-1:0]    prod_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic [0:NTAPS-1][CW-1:0] coef_arr_t;

  // SRRC prototype, 1s17; sum(|h|) = 120800 keeps acc[34:17] in range for any input
  localparam coef_arr_t H = '{
    -18'sd600,   -18'sd1400,  18'sd0,      18'sd2200,   18'sd2600,
     18'sd0,     -18'sd5200,  -18'sd7400,  18'sd0,      18'sd21000,
     18'sd40000,
     18'sd21000,  18'sd0,     -18'sd7400,  -18'sd5200,  18'sd0,
     18'sd2600,   18'sd2200,  18'sd0,      -18'sd1400,  -18'sd600
  };

endpackage

`default_nettype wire

// File: rtl/sym_fir_filter_if.sv
// Sample-stream bundle between the sample-rate source and the FIR filter.
// Revision 1.0 - initial release
`default_nettype none

interface sym_fir_filter_if;
  import fir_pkg::*;

  logic    sam_clk_en;
  sample_t x_in;
  sample_t y;

  modport master (output sam_clk_en, output x_in, input y);
  modport slave  (input sam_clk_en, input x_in, output y);

endinterface

`default_nettype wire

// File: rtl/fir_preadd_mult.sv
// One folded tap: pre-add the mirrored samples, then multiply at full precision.
// Revision 1.0 - initial release
`default_nettype none

module fir_preadd_mult
  import fir_pkg::*;
(
  input  sample_t a,
  input  sample_t b,
  input  coef_t   coef,
  output prod_t   prod
);

  logic signed [DW:0] pre_sum;

  assign pre_sum = {a[DW-1], a} + {b[DW-1], b};
  assign prod    = pre_sum * coef;

endmodule

`default_nettype wire

// File: rtl/sym_fir_filter.sv
// Symmetric direct-form FIR, one sample per sam_clk_en, registered 1s17 output.
// Revision 1.0 - initial release; FIR_OUTPUT_SAT_EN clamps y instead of wrapping.
`default_nettype none

module sym_fir_filter
  import fir_pkg::*;
#(
  parameter coef_arr_t COEFFS = H
) (
  input  logic             sys_clk,
  input  logic             rst,
  sym_fir_filter_if.slave  bus
);

  sample_t                  delay_line [NTAPS];
  prod_t                    prods [NHALF];
  logic signed [DW+CW-1:0]  centre;
  acc_t                     acc;
  sample_t                  y_next;
  sample_t                  y_reg;
  logic                     unused_acc_bits;

  for (genvar k = 0; k < NHALF; k++) begin : g_tap
    fir_preadd_mult u_tap (
      .a    (delay_line[k]),
      .b    (delay_line[NTAPS-1-k]),
      .coef (coef_t'(COEFFS[k])),
      .prod (prods[k])
    );
  end

  assign centre = delay_line[NHALF] * coef_t'(COEFFS[NHALF]);

  always_comb begin
    acc = acc_t'(centre);
    for (int k = 0; k < NHALF; k++) begin
      acc = acc + acc_t'(prods[k]);
    end
  end

`ifdef FIR_OUTPUT_SAT_EN
  // acc[ACC_W-1:34] must be pure sign extension for acc[34:17] to be exact
  always_comb begin
    y_next = acc[34:17];
    if (!acc[ACC_W-1] && (|acc[ACC_W-2:34])) begin
      y_next = {1'b0, {(DW-1){1'b1}}};
    end else if (acc[ACC_W-1] && !(&acc[ACC_W-2:34])) begin
      y_next = {1'b1, {(DW-1){1'b0}}};
    end
  end
`else
  assign y_next = acc[34:17];
`endif

  assign unused_acc_bits = ^{acc[ACC_W-1:35], acc[16:0]};

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        delay_line[i] <= '0;
      end
      y_reg <= '0;
    end else if (bus.sam_clk_en) begin
      y_reg         <= y_next;
      delay_line[0] <= bus.x_in;
      for (int i = 1; i < NTAPS; i++) begin
        delay_line[i] <= delay_line[i-1];
      end
    end
  end

  assign bus.y = y_reg;

endmodule

`default_nettype wire

// File: tb/tb_sym_fir_filter.sv
// Self-checking bench: vector table plus model-driven sequences, scoreboard compare.
// Revision 1.0 - initial release
`default_nettype none

module tb_sym_fir_filter;
  import fir_pkg::*;

  logic sys_clk = 1'b0;
  logic rst;
  always #5 sys_clk = ~sys_clk;

  localparam coef_arr_t HB = {NTAPS{18'd10000}};

  sym_fir_filter_if bus_a ();
  sym_fir_filter_if bus_b ();

  sym_fir_filter u_dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus_a)
  );

  sym_fir_filter #(.COEFFS(HB)) u_dut_sat (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus_b)
  );

  typedef struct {
    bit rst;
    bit en;
    int x;
    int exp_y;
  } vec_t;

  typedef struct {
    int    exp_y;
    string name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ha[NTAPS];
  int   hb[NTAPS];
  int   hist_a[NTAPS];
  int   hist_b[NTAPS];

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: y=%0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int shape(input longint acc);
    longint     s;
    logic [17:0] t;
    s = acc >>> 17;
`ifdef FIR_OUTPUT_SAT_EN
    if (s > 131071)  return 131071;
    if (s < -131072) return -131072;
    return int'(s);
`else
    t = s[17:0];
    return int'($signed(t));
`endif
  endfunction

  // Plain direct-form convolution over the pre-shift history
  function automatic int model(input int c[NTAPS], input int h[NTAPS]);
    longint acc = 0;
    for (int j = 0; j < NTAPS; j++) acc += longint'(c[j]) * longint'(h[j]);
    return shape(acc);
  endfunction

  task automatic shift_a(input int x);
    for (int j = NTAPS - 1; j > 0; j--) hist_a[j] = hist_a[j-1];
    hist_a[0] = x;
  endtask

  task automatic shift_b(input int x);
    for (int j = NTAPS - 1; j > 0; j--) hist_b[j] = hist_b[j-1];
    hist_b[0] = x;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_a.sam_clk_en = 1'b0;
    bus_b.sam_clk_en = 1'b0;
    tick();
    rst = 1'b0;
    for (int j = 0; j < NTAPS; j++) begin
      hist_a[j] = 0;
      hist_b[j] = 0;
    end
  endtask

  function automatic int rand_sample();
    return int'($urandom_range(262143)) - 131072;
  endfunction

  initial begin
    int   last;
    int   e;
    int   x;
    int   hsum;
    sb_t  got;

    rst = 1'b1;
    bus_a.sam_clk_en = 1'b0;
    bus_a.x_in = '0;
    bus_b.sam_clk_en = 1'b0;
    bus_b.x_in = '0;
    hsum = 0;
    for (int k = 0; k < NTAPS; k++) begin
      ha[k] = int'($signed(H[k]));
      hb[k] = 10000;
      hsum += ha[k];
    end

    // ---- vector table ----
    for (int i = 0; i < 5; i++) vecs.push_back('{1'b1, 1'b1, rand_sample(), 0});
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 1'b1, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 131071, 0});
    for (int k = 0; k < NTAPS; k++) begin
      e = int'((longint'(131071) * longint'(ha[k])) >>> 17);
      vecs.push_back('{1'b0, 1'b1, 0, e});
      if (k == 5) begin
        vecs.push_back('{1'b0, 1'b0, 77777, e});
        vecs.push_back('{1'b0, 1'b0, -5, e});
      end
    end
    for (int i = 0; i < 2; i++) vecs.push_back('{1'b0, 1'b1, 0, 0});
    vecs.push_back('{1'b0, 1'b1, -131072, 0});
    for (int k = 0; k < NTAPS; k++) vecs.push_back('{1'b0, 1'b1, 0, -ha[k]});
    vecs.push_back('{1'b0, 1'b1, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 131071, 0});
    for (int k = 0; k < 5; k++)
      vecs.push_back('{1'b0, 1'b1, 0, int'((longint'(131071) * longint'(ha[k])) >>> 17)});
    vecs.push_back('{1'b1, 1'b1, 131071, 0});
    for (int i = 0; i < NTAPS + 2; i++) vecs.push_back('{1'b0, 1'b1, 0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      bus_a.sam_clk_en = vecs[i].en;
      bus_a.x_in = sample_t'(vecs[i].x);
      sb.push_back('{vecs[i].exp_y, $sformatf("vec%0d", i)});
      tick();
      got = sb.pop_front();
      check(got.name, int'(bus_a.y), got.exp_y);
    end

    // ---- enable gating, one enable in four, input changes every cycle ----
    do_reset();
    last = 0;
    for (int c = 0; c < 48; c++) begin
      x = rand_sample();
      bus_a.x_in = sample_t'(x);
      bus_a.sam_clk_en = (c % 4 == 3);
      if (c % 4 == 3) begin
        last = model(ha, hist_a);
        shift_a(x);
      end
      sb.push_back('{last, $sformatf("gate%0d", c)});
      tick();
      got = sb.pop_front();
      check(got.name, int'(bus_a.y), got.exp_y);
    end

    // ---- DC step under continuous enable ----
    do_reset();
    bus_a.sam_clk_en = 1'b1;
    bus_a.x_in = sample_t'(65536);
    for (int c = 0; c < NTAPS + 3; c++) begin
      sb.push_back('{model(ha, hist_a), $sformatf("dc%0d", c)});
      shift_a(65536);
      tick();
      got = sb.pop_front();
      check(got.name, int'(bus_a.y), got.exp_y);
    end
    check("dc_final", int'(bus_a.y), hsum >>> 1);
    bus_a.sam_clk_en = 1'b0;

    // ---- over-range coefficient set: clamp or wrap ----
    do_reset();
    check("sat_reset", int'(bus_b.y), 0);
    bus_b.sam_clk_en = 1'b1;
    bus_b.x_in = sample_t'(131071);
    for (int c = 0; c < NTAPS + 2; c++) begin
      sb.push_back('{model(hb, hist_b), $sformatf("sat%0d", c)});
      shift_b(131071);
      tick();
      got = sb.pop_front();
      check(got.name, int'(bus_b.y), got.exp_y);
    end
`ifdef FIR_OUTPUT_SAT_EN
    check("sat_final", int'(bus_b.y), 131071);
`else
    check("wrap_final", int'(bus_b.y), -52146);
`endif
    check("idle_hold", int'(bus_a.y), 0);
    bus_b.sam_clk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
